float_accum_multichannel: RTL and testbench

Multi-channel FP32 accumulator. It holds CHANNELS independent IEEE-754 single-precision running sums, per-channel sample counters and sticky exception flags, and time-shares one `Float32Add` instance across all channels. Samples arrive over a valid/ready stream tagged with a channel index and an add/subtract/init opcode. Each completed operation is reported on a one-cycle result strobe, and any channel can be read combinationally at any time. It sits between the sample front-end and the statistics/readout logic.

---
 rtl/float_accum_multichannel.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_float_accum_multichannel.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_accum_multichannel.sv
// Multi-channel FP32 accumulator: per-channel running sums, saturating sample
// counters and sticky NaN/Inf/denormal flags, sharing one FP32 adder.

// Two-step FP32 adder: operands captured on loadArgs (busy = 1), result
// computed and registered on the following edge (busy = 0, sum valid).
module Float32Add (
    input  logic        clk,
    input  logic        resetn,
    input  logic        loadArgs,
    input  logic [31:0] leftArg,
    input  logic [31:0] rightArg,
    input  logic        addSub,     // 1 = add, 0 = subtract
    output logic        busy,
    output logic [31:0] sum
);
    logic [31:0] a_r;
    logic [31:0] b_r;               // right operand with sign already adjusted
    logic        busy_r;
    logic [31:0] sum_r;

    // Round-to-nearest-even FP32 addition with denormal support
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic [7:0]  ea, eb, eg, el, d;
        logic [23:0] mg, ml;
        logic        sg, sl, sticky, rnd_up;
        logic [26:0] xl, x;
        logic [27:0] m;
        logic [8:0]  e;
        logic [24:0] r;
        logic [4:0]  lz;
        res = 32'h0000_0000;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
            (a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h7F80_0000 && a[31] != b[31])) begin
            res = 32'h7FC0_0000;
        end else if (a[30:23] == 8'hFF) begin
            res = a;
        end else if (b[30:23] == 8'hFF) begin
            res = b;
        end else begin
            ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
            eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
            if (a[30:0] >= b[30:0]) begin
                sg = a[31]; eg = ea; mg = {a[30:23] != 8'd0, a[22:0]};
                sl = b[31]; el = eb; ml = {b[30:23] != 8'd0, b[22:0]};
            end else begin
                sg = b[31]; eg = eb; mg = {b[30:23] != 8'd0, b[22:0]};
                sl = a[31]; el = ea; ml = {a[30:23] != 8'd0, a[22:0]};
            end
            d  = eg - el;
            xl = {ml, 3'b000};
            sticky = 1'b0;
            if (d >= 8'd27) begin
                sticky = |ml;
                xl = 27'd0;
            end else begin
                for (int i = 0; i < 27; i++) begin
                    if (8'(i) < d) sticky = sticky | xl[i];
                    else sticky = sticky;
                end
                xl = xl >> d;
            end
            xl[0] = xl[0] | sticky;
            if (sg == sl) m = {1'b0, mg, 3'b000} + {1'b0, xl};
            else m = {1'b0, mg, 3'b000} - {1'b0, xl};
            e = {1'b0, eg};
            if (m == 28'd0) begin
                res = {sg & sl, 31'd0};
            end else begin
                if (m[27]) begin
                    x = m[27:1];
                    x[0] = m[1] | m[0];
                    e = e + 9'd1;
                end else begin
                    lz = 5'd27;
                    for (int i = 0; i < 27; i++) begin
                        if (m[i]) lz = 5'(26 - i);
                        else lz = lz;
                    end
                    // Stop normalising at the minimum exponent: result becomes denormal
                    if ({4'b0000, lz} > (e - 9'd1)) lz = 5'(e - 9'd1);
                    else lz = lz;
                    x = m[26:0] << lz;
                    e = e - {4'b0000, lz};
                end
                rnd_up = x[2] & (x[1] | x[0] | x[3]);
                r = {1'b0, x[26:3]} + {24'd0, rnd_up};
                if (r[24]) begin
                    r = r >> 1;
                    e = e + 9'd1;
                end else begin
                    r = r;
                end
                if (e >= 9'd255) res = {sg, 8'hFF, 23'd0};
                else if (!r[23]) res = {sg, 8'd0, r[22:0]};
                else res = {sg, e[7:0], r[22:0]};
            end
        end
        return res;
    endfunction

    // Operand capture and single-cycle compute
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_r    <= 32'h0000_0000;
            b_r    <= 32'h0000_0000;
            busy_r <= 1'b0;
            sum_r  <= 32'h0000_0000;
        end else if (loadArgs) begin
            a_r    <= leftArg;
            b_r    <= {rightArg[31] ^ ~addSub, rightArg[30:0]};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            sum_r  <= fp_add(a_r, b_r);
            busy_r <= 1'b0;
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign sum  = sum_r;
endmodule

module float_accum_multichannel #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [31:0]      rd_sum,
    output logic [CNT_W-1:0] rd_count,
    output logic [2:0]       rd_flags
);
    localparam logic [1:0]    OP_SUB  = 2'd1;
    localparam logic [1:0]    OP_INIT = 2'd2;
    localparam logic [CH_W:0] NUM_CH  = (CH_W+1)'(CHANNELS);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT1, WAIT, WRITE} state_t;

    state_t          state_r;
    logic [31:0]     acc_r   [CHANNELS];
    logic [CNT_W-1:0] cnt_r  [CHANNELS];
    logic [2:0]      flags_r [CHANNELS];
    logic [CH_W-1:0] ch_r;
    logic [31:0]     data_r;
    logic [1:0]      op_r;
    logic            load_args_r;
    logic            adder_busy_s;
    logic [31:0]     adder_sum_s;
    logic [31:0]     cur_acc_s;
    logic [CNT_W-1:0] cur_cnt_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic [2:0]      cur_flags_s;
    logic [31:0]     init_val_s;
    logic            init_op_s;
    logic            bad_ch_s;

    // Classification: {NaN, Inf, denormal}
    function automatic logic [2:0] fp_class(input logic [31:0] v);
        return {v[30:23] == 8'hFF && v[22:0] != 23'd0,
                v[30:23] == 8'hFF && v[22:0] == 23'd0,
                v[30:23] == 8'h00 && v[22:0] != 23'd0};
    endfunction

    Float32Add u_add (
        .clk      (clk),
        .resetn   (resetn),
        .loadArgs (load_args_r),
        .leftArg  (cur_acc_s),
        .rightArg (data_r),
        .addSub   (op_r != OP_SUB),
        .busy     (adder_busy_s),
        .sum      (adder_sum_s)
    );

    assign in_ready = (state_r == IDLE);

    // Channel muxes for the read port and the channel of the op in flight
    always_comb begin
        rd_sum      = 32'h0000_0000;
        rd_count    = {CNT_W{1'b0}};
        rd_flags    = 3'b000;
        cur_acc_s   = 32'h0000_0000;
        cur_cnt_s   = {CNT_W{1'b0}};
        cur_flags_s = 3'b000;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_sum   = acc_r[i];
                rd_count = cnt_r[i];
                rd_flags = flags_r[i];
            end else begin
                rd_sum = rd_sum;
            end
            if (ch_r == CH_W'(i)) begin
                cur_acc_s   = acc_r[i];
                cur_cnt_s   = cnt_r[i];
                cur_flags_s = flags_r[i];
            end else begin
                cur_acc_s = cur_acc_s;
            end
        end
        if (cur_cnt_s == {CNT_W{1'b1}}) next_cnt_s = cur_cnt_s;
        else next_cnt_s = cur_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
        init_op_s = (in_op == OP_INIT);
        if (init_op_s) init_val_s = in_data;
        else init_val_s = 32'h0000_0000;
        bad_ch_s = ({1'b0, in_ch} >= NUM_CH);
    end

    // Control FSM, accumulator state and registered result strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            ch_r        <= {CH_W{1'b0}};
            data_r      <= 32'h0000_0000;
            op_r        <= 2'd0;
            load_args_r <= 1'b0;
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            out_ch      <= {CH_W{1'b0}};
            out_sum     <= 32'h0000_0000;
            out_count   <= {CNT_W{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i]   <= 32'h0000_0000;
                cnt_r[i]   <= {CNT_W{1'b0}};
                flags_r[i] <= 3'b000;
            end
        end else begin
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            load_args_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ch_r   <= in_ch;
                        data_r <= in_data;
                        op_r   <= in_op;
                        if (bad_ch_s) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_ch    <= in_ch;
                            out_sum   <= 32'h0000_0000;
                            out_count <= {CNT_W{1'b0}};
                        end else if (in_op[1]) begin
                            for (int i = 0; i < CHANNELS; i++) begin
                                if (in_ch == CH_W'(i)) begin
                                    acc_r[i]   <= init_val_s;
                                    cnt_r[i]   <= {{(CNT_W-1){1'b0}}, init_op_s};
                                    flags_r[i] <= init_op_s ? fp_class(in_data) : 3'b000;
                                end else begin
                                    acc_r[i] <= acc_r[i];
                                end
                            end
                            out_valid <= 1'b1;
                            out_ch    <= in_ch;
                            out_sum   <= init_val_s;
                            out_count <= {{(CNT_W-1){1'b0}}, init_op_s};
                        end else begin
                            load_args_r <= 1'b1;
                            state_r     <= LOAD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD:  state_r <= WAIT1;
                WAIT1: state_r <= WAIT;
                WAIT: begin
                    // Result is committed on the edge that enters WRITE
                    if (!adder_busy_s) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (ch_r == CH_W'(i)) begin
                                acc_r[i]   <= adder_sum_s;
                                cnt_r[i]   <= next_cnt_s;
                                flags_r[i] <= cur_flags_s | fp_class(adder_sum_s);
                            end else begin
                                acc_r[i] <= acc_r[i];
                            end
                        end
                        out_valid <= 1'b1;
                        out_ch    <= ch_r;
                        out_sum   <= adder_sum_s;
                        out_count <= next_cnt_s;
                        state_r   <= WRITE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WRITE:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_accum_multichannel.sv
// Scoreboard bench for float_accum_multichannel (3 channels, 4-bit counters
// so that the bad-channel index and counter saturation are reachable).
module tb_float_accum_multichannel;
    localparam int CHANNELS = 3;
    localparam int CNT_W    = 4;
    localparam int CH_W     = 2;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_INIT = 2'd2, OP_CLR = 2'd3;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'h0;
    logic [CH_W-1:0]  in_ch = 2'd0;
    logic [1:0]       in_op = 2'd0;
    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
    logic [CH_W-1:0]  rd_ch = 2'd0;
    logic [31:0]      rd_sum;
    logic [CNT_W-1:0] rd_count;
    logic [2:0]       rd_flags;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [31:0]      sum;
        logic [CNT_W-1:0] cnt;
        logic             err;
        int               due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    float_accum_multichannel #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ch(in_ch), .in_op(in_op),
        .out_valid(out_valid), .out_ch(out_ch), .out_sum(out_sum),
        .out_count(out_count), .out_err(out_err),
        .rd_ch(rd_ch), .rd_sum(rd_sum), .rd_count(rd_count), .rd_flags(rd_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL strobe: unexpected out_valid ch=%0d sum=%h cnt=%0d err=%b, required no strobe",
                         out_ch, out_sum, out_count, out_err);
            end else begin
                mon_e = sb_q.pop_front();
                if (out_ch !== mon_e.ch || out_sum !== mon_e.sum || out_count !== mon_e.cnt ||
                    out_err !== mon_e.err || cyc != mon_e.due) begin
                    fails++;
                    $display("FAIL result: got ch=%0d sum=%h cnt=%0d err=%b cyc=%0d, required ch=%0d sum=%h cnt=%0d err=%b cyc=%0d",
                             out_ch, out_sum, out_count, out_err, cyc,
                             mon_e.ch, mon_e.sum, mon_e.cnt, mon_e.err, mon_e.due);
                end
            end
        end
    end

    // Issue one transfer; push its expected strobe (init/clear/error: on the
    // transfer edge, add/sub: three edges later)
    task automatic send(input logic [CH_W-1:0] ch, input logic [1:0] op, input logic [31:0] data,
                        input logic [31:0] esum, input logic [CNT_W-1:0] ecnt, input logic eerr,
                        input bit exp_out);
        int   waited;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch;
        in_op    = op;
        in_data  = data;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL handshake: in_ready=0 after %0d cycles, required 1", waited);
            in_valid = 1'b0;
        end else begin
            e.ch  = ch;
            e.sum = esum;
            e.cnt = ecnt;
            e.err = eerr;
            e.due = cyc + 1 + ((!eerr && !op[1]) ? 3 : 0);
            if (exp_out) sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) until every expected strobe has been seen
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_rd(input string name, input logic [CH_W-1:0] ch, input logic [31:0] esum,
                            input logic [CNT_W-1:0] ecnt, input logic [2:0] eflags);
        @(negedge clk);
        rd_ch = ch;
        #1;
        tests++;
        if (rd_sum !== esum || rd_count !== ecnt || rd_flags !== eflags) begin
            fails++;
            $display("FAIL %s: ch%0d got sum=%h cnt=%0d flags=%b, required sum=%h cnt=%0d flags=%b",
                     name, ch, rd_sum, rd_count, rd_flags, esum, ecnt, eflags);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || out_ch !== 2'd0 ||
            out_sum !== 32'h0 || out_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_out: rdy=%b vld=%b err=%b ch=%0d sum=%h cnt=%0d, required 1 0 0 0 0 0",
                     in_ready, out_valid, out_err, out_ch, out_sum, out_count);
        end
        resetn = 1'b1;
        for (int c = 0; c < CHANNELS; c++) check_rd("reset_rd", 2'(c), 32'h0, 4'd0, 3'b000);

        // 1.0 + 2.0 = 3.0 on ch0
        send(2'd0, OP_INIT, 32'h3F80_0000, 32'h3F80_0000, 4'd1, 1'b0, 1'b1);
        send(2'd0, OP_ADD,  32'h4000_0000, 32'h4040_0000, 4'd2, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: in_ready=%b during add, required 0", in_ready);
        end
        drain();
        check_rd("ch0_sum", 2'd0, 32'h4040_0000, 4'd2, 3'b000);

        // Back-to-back clears, then interleaved ch1 += 0.5 and ch2 -= 1.0
        send(2'd1, OP_CLR, 32'h1234_5678, 32'h0, 4'd0, 1'b0, 1'b1);
        send(2'd2, OP_CLR, 32'h0,         32'h0, 4'd0, 1'b0, 1'b1);
        send(2'd1, OP_ADD, 32'h3F00_0000, 32'h3F00_0000, 4'd1, 1'b0, 1'b1);
        send(2'd2, OP_SUB, 32'h3F80_0000, 32'hBF80_0000, 4'd1, 1'b0, 1'b1);
        send(2'd1, OP_ADD, 32'h3F00_0000, 32'h3F80_0000, 4'd2, 1'b0, 1'b1);
        send(2'd2, OP_SUB, 32'h3F80_0000, 32'hC000_0000, 4'd2, 1'b0, 1'b1);
        send(2'd1, OP_ADD, 32'h3F00_0000, 32'h3FC0_0000, 4'd3, 1'b0, 1'b1);
        send(2'd1, OP_ADD, 32'h3F00_0000, 32'h4000_0000, 4'd4, 1'b0, 1'b1);
        drain();
        check_rd("ch1_sum", 2'd1, 32'h4000_0000, 4'd4, 3'b000);
        check_rd("ch2_sum", 2'd2, 32'hC000_0000, 4'd2, 3'b000);
        check_rd("ch0_keep", 2'd0, 32'h4040_0000, 4'd2, 3'b000);

        // +Inf - +Inf = NaN; Inf flag stays sticky; clear wipes everything
        send(2'd2, OP_INIT, 32'h7F80_0000, 32'h7F80_0000, 4'd1, 1'b0, 1'b1);
        send(2'd2, OP_SUB,  32'h7F80_0000, 32'h7FC0_0000, 4'd2, 1'b0, 1'b1);
        drain();
        check_rd("nan_flags", 2'd2, 32'h7FC0_0000, 4'd2, 3'b110);
        send(2'd2, OP_CLR, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1);
        drain();
        check_rd("clr_flags", 2'd2, 32'h0, 4'd0, 3'b000);

        // Counter saturation at 15 with 4-bit counters
        send(2'd0, OP_CLR, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++)
            send(2'd0, OP_ADD, 32'h0, 32'h0, 4'((k > 15) ? 15 : k), 1'b0, 1'b1);
        drain();
        check_rd("sat_count", 2'd0, 32'h0, 4'd15, 3'b000);

        // Out-of-range channel: error strobe, nothing changes
        send(2'd3, OP_INIT, 32'h3F80_0000, 32'h0, 4'd0, 1'b1, 1'b1);
        send(2'd3, OP_ADD,  32'h3F80_0000, 32'h0, 4'd0, 1'b1, 1'b1);
        drain();
        check_rd("err_ch0", 2'd0, 32'h0, 4'd15, 3'b000);
        check_rd("err_ch1", 2'd1, 32'h4000_0000, 4'd4, 3'b000);
        check_rd("err_ch2", 2'd2, 32'h0, 4'd0, 3'b000);

        // Second add held on in_valid while the first is in flight
        send(2'd1, OP_ADD, 32'h3F80_0000, 32'h4040_0000, 4'd5, 1'b0, 1'b1);
        send(2'd1, OP_ADD, 32'h3F80_0000, 32'h4080_0000, 4'd6, 1'b0, 1'b1);
        drain();
        check_rd("held_ch1", 2'd1, 32'h4080_0000, 4'd6, 3'b000);

        // Reset while the adder result is being waited for
        send(2'd1, OP_ADD, 32'h3F80_0000, 32'h0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        for (int c = 0; c < CHANNELS; c++) check_rd("abort_rd", 2'(c), 32'h0, 4'd0, 3'b000);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d expectations unmatched, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
